// File: rtl/varredura_mostrador_pkg.sv
// Shared types and defaults for the multiplexed display scanner.
package varredura_mostrador_pkg;

    localparam int unsigned CodeW       = 4;
    localparam int unsigned DefNCol     = 5;
    localparam int unsigned DefDiv      = 1000;
    localparam int unsigned DefBlankCyc = 2;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StBlank,
        StSwap
    } state_e;

endpackage

// File: rtl/varredura_mostrador_if.sv
// Load handshake and display-side signals of the scanner.
// blink_mask exists only when VARREDURA_BLINK_EN is defined.
interface varredura_mostrador_if #(
    parameter int unsigned N_COL = varredura_mostrador_pkg::DefNCol
);
    import varredura_mostrador_pkg::*;

    localparam int unsigned IDXW = (N_COL > 1) ? $clog2(N_COL) : 1;

    logic               scan_en;
    logic               load_valid;
    logic               load_ready;
    logic [IDXW-1:0]    load_idx;
    logic [CodeW-1:0]   load_code;
    logic [CodeW-1:0]   code;
    logic [N_COL-1:0]   col_sel;
    logic               frame_done;
`ifdef VARREDURA_BLINK_EN
    logic [N_COL-1:0]   blink_mask;
`endif

    modport master (
`ifdef VARREDURA_BLINK_EN
        output blink_mask,
`endif
        output scan_en, load_valid, load_idx, load_code,
        input  load_ready, code, col_sel, frame_done
    );

    modport slave (
`ifdef VARREDURA_BLINK_EN
        input  blink_mask,
`endif
        input  scan_en, load_valid, load_idx, load_code,
        output load_ready, code, col_sel, frame_done
    );

endinterface

// File: rtl/varredura_temporizador.sv
// Down-counter with load; tc is high while the count sits at zero.
module varredura_temporizador #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/varredura_mostrador.sv
// Column-multiplexed display scanner with double-buffered symbol codes.
// Optional column blinking is compiled in with VARREDURA_BLINK_EN.
module varredura_mostrador
    import varredura_mostrador_pkg::*;
#(
    parameter int unsigned N_COL     = DefNCol,
    parameter int unsigned DIV       = DefDiv,
    parameter int unsigned BLANK_CYC = DefBlankCyc
`ifdef VARREDURA_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    varredura_mostrador_if.slave  bus
);

    localparam int unsigned IdxW   = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int unsigned MaxCyc = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] ShowLoad  = CntW'(DIV - 1);
    localparam logic [CntW-1:0] BlankLoad = CntW'(BLANK_CYC - 1);
    localparam logic [IdxW-1:0] LastCol   = IdxW'(N_COL - 1);
    localparam logic [IdxW:0]   NColW     = (IdxW + 1)'(N_COL);

    state_e             state_q, state_d;
    logic [IdxW-1:0]    col_q, col_d;
    logic [CodeW-1:0]   code_q, code_d;
    logic [CodeW-1:0]   shadow_q [N_COL];
    logic [CodeW-1:0]   active_q [N_COL];
    logic [CodeW-1:0]   active_nx [N_COL];
    logic               tc;
    logic               tmr_load;
    logic [CntW-1:0]    tmr_val;
    logic               wr_en;
    logic [N_COL-1:0]   blink_gate;
    logic [N_COL-1:0]   col_sel_c;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        unique case (state_q)
            StIdle: begin
                if (bus.scan_en) begin
                    state_d = StShow;
                    col_d   = '0;
                end
            end
            StShow: begin
                if (tc) state_d = StBlank;
            end
            StBlank: begin
                if (tc) begin
                    if (col_q == LastCol) begin
                        state_d = StSwap;
                        col_d   = '0;
                    end else begin
                        state_d = StShow;
                        col_d   = col_q + 1'b1;
                    end
                end
            end
            StSwap: begin
                state_d = bus.scan_en ? StShow : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Every state change reloads the timer, so SHOW and BLANK each start a fresh count.
    assign tmr_load = (state_d != state_q);
    assign tmr_val  = (state_d == StBlank) ? BlankLoad : ShowLoad;

    varredura_temporizador #(
        .W (CntW)
    ) u_temporizador (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tc)
    );

    // The swap result feeds the code register directly so the first column of the
    // new frame already shows the freshly copied buffer.
    always_comb begin
        for (int i = 0; i < N_COL; i++) begin
            active_nx[i] = (state_q == StSwap) ? shadow_q[i] : active_q[i];
        end
        code_d = code_q;
        if (state_d == StShow) begin
            code_d = active_nx[col_d];
        end else if (state_d == StIdle) begin
            code_d = '0;
        end
    end

    assign bus.load_ready = ~rst & (state_q != StSwap);
    assign wr_en = bus.load_valid & bus.load_ready & ({1'b0, bus.load_idx} < NColW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            code_q  <= '0;
            for (int i = 0; i < N_COL; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            code_q  <= code_d;
            for (int i = 0; i < N_COL; i++) begin
                active_q[i] <= active_nx[i];
            end
            if (wr_en) shadow_q[bus.load_idx] <= bus.load_code;
        end
    end

`ifdef VARREDURA_BLINK_EN
    localparam int unsigned FcW = $clog2(BLINK_FRAMES + 1);

    logic [FcW-1:0] frame_cnt_q;
    logic           blink_off_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else if (state_q == StSwap) begin
            if (frame_cnt_q == FcW'(BLINK_FRAMES - 1)) begin
                frame_cnt_q <= '0;
                blink_off_q <= ~blink_off_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign blink_gate = blink_off_q ? bus.blink_mask : '0;
`else
    assign blink_gate = '0;
`endif

    always_comb begin
        col_sel_c = '0;
        if (state_q == StShow) col_sel_c[col_q] = 1'b1;
    end

    assign bus.col_sel    = col_sel_c & ~blink_gate;
    assign bus.code       = code_q;
    assign bus.frame_done = (state_q == StSwap);

endmodule

// File: doc/varredura_mostrador.md
VARREDURA_MOSTRADOR -- requirements
Module: varredura_mostrador

Interface
REQ-001 SHALL have parameter N_COL, default 5: number of multiplexed display columns.
REQ-002 SHALL have parameter DIV, default 1000: clock cycles each column is lit (min 1).
REQ-003 SHALL have parameter BLANK_CYC, default 2: all-off cycles between columns (min 1).
REQ-004 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port scan_en, input, 1: enables scanning; sampled only in IDLE and SWAP.
REQ-007 SHALL have port load_valid, input, 1: write request into shadow buffer.
REQ-008 SHALL have port load_ready, output, 1: shadow buffer accepts a write this cycle.
REQ-009 SHALL have port load_idx, input, clog2(N_COL): target column of write.
REQ-010 SHALL have port load_code, input, 4: symbol code for target column.
REQ-011 SHALL have port code, output, 4: {a,b,c,d} to the display decoder; bit 3 = a.
REQ-012 SHALL have port col_sel, output, N_COL: one-hot column enable, active-high.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse at each frame end.

Function
REQ-014 SHALL hold two N_COL x 4-bit buffers: shadow (written) and active (displayed).
REQ-015 SHALL accept a write when load_valid && load_ready; shadow[load_idx] updated next edge.
REQ-016 SHALL silently drop writes with load_idx >= N_COL; handshake still completes.
REQ-017 SHALL drive load_ready high in all states except SWAP and reset.
REQ-018 SHALL implement FSM states IDLE, SHOW, BLANK, SWAP.
REQ-019 IDLE: col_sel=0, code=0; go to SHOW with column 0 when scan_en=1.
REQ-020 SHOW: col_sel=one-hot(col), code=active[col] registered; after DIV cycles go to BLANK.
REQ-021 BLANK: col_sel=0, code held; after BLANK_CYC cycles col increments.
REQ-022 Column increment: col<N_COL-1 -> SHOW with col+1; col=N_COL-1 -> SWAP, col wraps to 0.
REQ-023 SWAP: exactly 1 cycle; active<=shadow, frame_done=1; then SHOW if scan_en=1, else IDLE.
REQ-024 Write accepted in the cycle before SWAP SHALL be included in the swap.
REQ-025 scan_en deassert mid-frame SHALL NOT truncate the frame; exit occurs at SWAP.
REQ-026 Frame length SHALL be N_COL*(DIV+BLANK_CYC)+1 cycles; col_sel never has >1 bit set.

Reset
REQ-027 On rst: state=IDLE, col=0, counters=0, code=0, col_sel=0, frame_done=0, load_ready=0.
REQ-028 On rst: both buffers cleared to 0; first cycle after rst release load_ready=1.
REQ-029 rst mid-frame SHALL force col_sel=0 immediately (asynchronously).

Configuration
REQ-030 With macro VARREDURA_BLINK_EN defined: add input blink_mask [N_COL] and parameter BLINK_FRAMES (default 32).
REQ-031 With VARREDURA_BLINK_EN: frame counter toggles blink phase every BLINK_FRAMES frames; in off phase masked columns have col_sel bit 0 during SHOW; timing unchanged.
REQ-032 Without VARREDURA_BLINK_EN: no blink_mask port, no frame counter; all columns always lit in SHOW.

Structure
REQ-033 Shared package SHALL hold state enum (IDLE/SHOW/BLANK/SWAP), code width constant 4, and default DIV/BLANK_CYC/N_COL values.
REQ-034 One sub-module, varredura_temporizador (cycle down-counter with load and terminal-count pulse), SHALL serve both the SHOW and BLANK timing.

Verification (N_COL=5, DIV=4, BLANK_CYC=2)
REQ-035 Reset then scan_en=1, no writes -> col_sel walks 00001..10000, 4 cycles lit + 2 dark each; code=0; frame_done every 31 cycles.
REQ-036 Write idx0..4 codes 1,2,3,4,5 while IDLE, then scan_en=1 -> first frame shows 0s, second frame code=1..5 aligned with col_sel bits 0..4.
REQ-037 Write idx2=9 during col 2 SHOW -> code for col 2 unchanged until after next frame_done, then 9.
REQ-038 load_valid=1 idx=7 -> load_ready=1, no buffer change; load_valid during SWAP -> load_ready=0, write held until next cycle.
REQ-039 Drop scan_en at col 1 -> scan completes col 4, SWAP, then IDLE with col_sel=0.
REQ-040 Assert rst during col 3 SHOW -> col_sel=0 in same cycle, all outputs at reset values, buffers 0.
